// File: rtl/snake_pkg.sv
// Shared encodings, colours and FSM state type for the snake body engine.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [2:0] COL_BG   = 3'b000;
  localparam logic [2:0] COL_BODY = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_MOVE, ST_SCAN, ST_ERASE, ST_DRAW, ST_WRITE, ST_DONE
  } state_t;

  // Opposite pairs differ only in bit 0 (up/down, left/right).
  function automatic logic [1:0] opposite(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/snake_body_ram.sv
// Synchronous single-port RAM holding snake cell coordinates; 1-cycle read latency.
module snake_body_ram
  import snake_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WIDTH = 11,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/snake_body_engine.sv
// Grid snake body engine: circular cell buffer, collision scan, erase/draw pixel stream.
// Define SNAKE_WRAP_EN to wrap at grid edges instead of dying.
// IDLE wait | INIT seed body | MOVE pick cell | SCAN check body | ERASE clear tail | DRAW paint head | WRITE commit | DONE pulse
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int MAX_LEN  = 256,
  parameter int INIT_LEN = 3,
  parameter int CELL_PX  = 4,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          step,
  input  logic [1:0]    dir,
  input  logic [XW-1:0] food_x,
  input  logic [YW-1:0] food_y,
  output logic          busy,
  output logic          done,
  output logic          ate,
  output logic          dead,
  output logic [LW-1:0] length,
  output logic          plot_en,
  output logic [7:0]    plot_x,
  output logic [6:0]    plot_y,
  output logic [2:0]    plot_colour
);

  localparam int PW   = $clog2(MAX_LEN);
  localparam int CW   = XW + YW;
  localparam int NPIX = CELL_PX * CELL_PX;
  localparam int KW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [XW-1:0] X_MID = XW'(GRID_W / 2);
  localparam logic [YW-1:0] Y_MID = YW'(GRID_H / 2);
`ifdef SNAKE_WRAP_EN
  localparam bit WALL_KILLS = 1'b0;
`else
  localparam bit WALL_KILLS = 1'b1;
`endif

  state_t        state;
  logic [PW-1:0] hd_ptr, tl_ptr, scan_ptr, init_idx;
  logic [LW-1:0] scan_cnt;
  logic [1:0]    dir_q, last_dir, mv_dir, eff_dir;
  logic [XW-1:0] head_x, nxt_x, tail_x, mv_x, cell_x, rd_x;
  logic [YW-1:0] head_y, nxt_y, tail_y, mv_y, cell_y, rd_y;
  logic          grow, hit, rd_tail, rd_valid, init_wr, wall, pop, match;
  logic [KW-1:0] pix_cnt, pix_k;
  logic [7:0]    px;
  logic [6:0]    py;
  logic          ram_we;
  logic [PW-1:0] ram_addr;
  logic [CW-1:0] ram_wdata, ram_rdata;

  snake_body_ram #(.DEPTH(MAX_LEN), .WIDTH(CW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    eff_dir = (dir_q == opposite(last_dir)) ? last_dir : dir_q;
    mv_x = head_x;
    mv_y = head_y;
    wall = 1'b0;
    case (eff_dir)
      DIR_UP:
        if (head_y == '0) begin mv_y = YW'(GRID_H - 1); wall = WALL_KILLS; end
        else mv_y = head_y - 1'b1;
      DIR_DOWN:
        if (head_y == YW'(GRID_H - 1)) begin mv_y = '0; wall = WALL_KILLS; end
        else mv_y = head_y + 1'b1;
      DIR_LEFT:
        if (head_x == '0) begin mv_x = XW'(GRID_W - 1); wall = WALL_KILLS; end
        else mv_x = head_x - 1'b1;
      default:
        if (head_x == XW'(GRID_W - 1)) begin mv_x = '0; wall = WALL_KILLS; end
        else mv_x = head_x + 1'b1;
    endcase
  end

  // A full snake that eats still drops its tail, so the tail cell vacates then too.
  assign pop   = !grow || (length == LW'(MAX_LEN));
  assign rd_x  = ram_rdata[CW-1:YW];
  assign rd_y  = ram_rdata[YW-1:0];
  assign match = rd_valid && (rd_x == nxt_x) && (rd_y == nxt_y) && !(rd_tail && pop);

  always_comb begin
    cell_x = nxt_x;
    cell_y = nxt_y;
    if (state == ST_INIT) begin
      cell_x = X_MID;
      cell_y = Y_MID + YW'(init_idx);
    end else if (state == ST_ERASE) begin
      cell_x = tail_x;
      cell_y = tail_y;
    end
    pix_k = KW'(NPIX - 1) - pix_cnt;
    px    = 8'(int'(cell_x) * CELL_PX + int'(pix_k) % CELL_PX);
    py    = 7'(int'(cell_y) * CELL_PX + int'(pix_k) / CELL_PX);
  end

  always_comb begin
    ram_we    = (state == ST_INIT && init_wr) || state == ST_WRITE;
    ram_addr  = scan_ptr;
    ram_wdata = {nxt_x, nxt_y};
    if (state == ST_INIT) begin
      ram_addr  = PW'(INIT_LEN - 1) - init_idx;
      ram_wdata = {cell_x, cell_y};
    end else if (state == ST_WRITE) begin
      ram_addr = hd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      hd_ptr      <= '0;
      tl_ptr      <= '0;
      scan_ptr    <= '0;
      init_idx    <= '0;
      scan_cnt    <= '0;
      dir_q       <= DIR_UP;
      last_dir    <= DIR_UP;
      mv_dir      <= DIR_UP;
      head_x      <= '0;
      head_y      <= '0;
      nxt_x       <= '0;
      nxt_y       <= '0;
      tail_x      <= '0;
      tail_y      <= '0;
      grow        <= 1'b0;
      hit         <= 1'b0;
      rd_tail     <= 1'b0;
      rd_valid    <= 1'b0;
      init_wr     <= 1'b0;
      pix_cnt     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ate         <= 1'b0;
      dead        <= 1'b0;
      length      <= LW'(1);
      plot_en     <= 1'b0;
      plot_x      <= '0;
      plot_y      <= '0;
      plot_colour <= '0;
    end else begin
      done    <= 1'b0;
      ate     <= 1'b0;
      plot_en <= 1'b0;
      if (start) begin
        state    <= ST_INIT;
        busy     <= 1'b1;
        dead     <= 1'b0;
        init_idx <= PW'(INIT_LEN - 1);
        init_wr  <= 1'b1;
        tl_ptr   <= '0;
        hd_ptr   <= PW'(INIT_LEN - 1);
        last_dir <= DIR_UP;
        head_x   <= X_MID;
        head_y   <= Y_MID;
      end else begin
        case (state)
          ST_IDLE:
            if (step && !dead) begin
              dir_q <= dir;
              busy  <= 1'b1;
              state <= ST_MOVE;
            end
          ST_INIT:
            if (init_wr) begin
              init_wr <= 1'b0;
              pix_cnt <= KW'(NPIX - 1);
            end else begin
              plot_en     <= 1'b1;
              plot_x      <= px;
              plot_y      <= py;
              plot_colour <= COL_BODY;
              if (pix_cnt == '0) begin
                if (init_idx == '0) begin
                  done   <= 1'b1;
                  length <= LW'(INIT_LEN);
                  state  <= ST_DONE;
                end else begin
                  init_idx <= init_idx - 1'b1;
                  init_wr  <= 1'b1;
                end
              end else begin
                pix_cnt <= pix_cnt - 1'b1;
              end
            end
          ST_MOVE: begin
            mv_dir   <= eff_dir;
            nxt_x    <= mv_x;
            nxt_y    <= mv_y;
            grow     <= (mv_x == food_x) && (mv_y == food_y);
            scan_ptr <= tl_ptr;
            scan_cnt <= length;
            rd_valid <= 1'b0;
            hit      <= 1'b0;
            if (wall) begin
              dead  <= 1'b1;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_SCAN;
            end
          end
          ST_SCAN: begin
            rd_valid <= (scan_cnt != '0);
            rd_tail  <= (scan_ptr == tl_ptr);
            scan_ptr <= scan_ptr + 1'b1;
            if (rd_valid && rd_tail) begin
              tail_x <= rd_x;
              tail_y <= rd_y;
            end
            if (scan_cnt != '0) begin
              scan_cnt <= scan_cnt - 1'b1;
              hit      <= hit | match;
            end else if (hit || match) begin
              dead  <= 1'b1;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              pix_cnt <= KW'(NPIX - 1);
              state   <= pop ? ST_ERASE : ST_DRAW;
            end
          end
          ST_ERASE: begin
            plot_en     <= 1'b1;
            plot_x      <= px;
            plot_y      <= py;
            plot_colour <= COL_BG;
            if (pix_cnt == '0) begin
              tl_ptr  <= tl_ptr + 1'b1;
              pix_cnt <= KW'(NPIX - 1);
              state   <= ST_DRAW;
            end else begin
              pix_cnt <= pix_cnt - 1'b1;
            end
          end
          ST_DRAW: begin
            plot_en     <= 1'b1;
            plot_x      <= px;
            plot_y      <= py;
            plot_colour <= COL_BODY;
            if (pix_cnt == '0) state <= ST_WRITE;
            else pix_cnt <= pix_cnt - 1'b1;
          end
          ST_WRITE: begin
            hd_ptr   <= hd_ptr + 1'b1;
            head_x   <= nxt_x;
            head_y   <= nxt_y;
            last_dir <= mv_dir;
            done     <= 1'b1;
            ate      <= grow;
            if (!pop) length <= length + 1'b1;
            state    <= ST_DONE;
          end
          ST_DONE: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snake_body_engine.sv
// Self-checking bench for snake_body_engine: vector table, edge sequence, pixel scoreboard.
module tb_snake_body_engine;
  import snake_pkg::*;

  localparam int GW = 40;
  localparam int GH = 30;
  localparam int XW = 6;
  localparam int YW = 5;
  localparam int LW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          step = 1'b0;
  logic [1:0]    dir = 2'b00;
  logic [XW-1:0] food_x = '0;
  logic [YW-1:0] food_y = '0;
  logic          busy, done, ate, dead, plot_en;
  logic [LW-1:0] length;
  logic [7:0]    plot_x;
  logic [6:0]    plot_y;
  logic [2:0]    plot_colour;

  snake_body_engine dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .dir(dir),
    .food_x(food_x), .food_y(food_y), .busy(busy), .done(done), .ate(ate),
    .dead(dead), .length(length), .plot_en(plot_en), .plot_x(plot_x),
    .plot_y(plot_y), .plot_colour(plot_colour)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {int x; int y; int c;} pix_t;
  pix_t exp_q[$];
  pix_t mp;

  int bx[$];
  int by[$];
  logic [1:0] m_last;
  int m_lat, m_len;
  bit m_ate, m_dead;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && plot_en) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL plot_unexpected: got pixel (%0d,%0d) colour %0d, expected none",
                 plot_x, plot_y, plot_colour);
      end else begin
        mp = exp_q.pop_front();
        n_checks--;
        check("plot_x", int'(plot_x), mp.x);
        check("plot_y", int'(plot_y), mp.y);
        check("plot_colour", int'(plot_colour), mp.c);
      end
    end
  end

  task automatic push_cell(input int cx, input int cy, input int c);
    pix_t p;
    for (int k = 0; k < 16; k++) begin
      p.x = cx * 4 + k % 4;
      p.y = cy * 4 + k / 4;
      p.c = c;
      exp_q.push_back(p);
    end
  endtask

  task automatic model_start();
    bx.delete();
    by.delete();
    for (int i = 2; i >= 0; i--) begin
      push_cell(GW / 2, GH / 2 + i, 2);
      bx.push_back(GW / 2);
      by.push_back(GH / 2 + i);
    end
    m_last = DIR_UP;
    m_lat = 52; m_ate = 0; m_dead = 0; m_len = 3;
  endtask

  task automatic model_step(input logic [1:0] d, input int fx, input int fy);
    logic [1:0] eff;
    int nx, ny;
    bit wall, grow, hit;
    eff = (d == {m_last[1], ~m_last[0]}) ? m_last : d;
    nx = bx[$];
    ny = by[$];
    wall = 0;
    case (eff)
      DIR_UP:   ny = ny - 1;
      DIR_DOWN: ny = ny + 1;
      DIR_LEFT: nx = nx - 1;
      default:  nx = nx + 1;
    endcase
    if (nx < 0)   begin nx = GW - 1; wall = 1; end
    if (nx >= GW) begin nx = 0;      wall = 1; end
    if (ny < 0)   begin ny = GH - 1; wall = 1; end
    if (ny >= GH) begin ny = 0;      wall = 1; end
`ifdef SNAKE_WRAP_EN
    wall = 0;
`endif
    m_len = bx.size();
    m_ate = 0;
    if (wall) begin
      m_dead = 1; m_lat = -1;
      return;
    end
    grow = (nx == fx) && (ny == fy);
    hit = 0;
    for (int i = 0; i < bx.size(); i++)
      if (bx[i] == nx && by[i] == ny && !(i == 0 && !grow)) hit = 1;
    if (hit) begin
      m_dead = 1; m_lat = 1 + m_len + 1 + 1;
      return;
    end
    m_lat = 1 + (m_len + 1) + (grow ? 0 : 16) + 16 + 2;
    if (!grow) begin
      push_cell(bx[0], by[0], 0);
      void'(bx.pop_front());
      void'(by.pop_front());
    end
    push_cell(nx, ny, 2);
    bx.push_back(nx);
    by.push_back(ny);
    m_last = eff;
    m_ate = grow;
    m_len = bx.size();
    m_dead = 0;
  endtask

  task automatic run_op(input bit is_start, input logic [1:0] d, input int fx, input int fy,
                        output int lat, output int got_ate, output int got_dead, output int got_len);
    @(negedge clk);
    food_x = XW'(fx);
    food_y = YW'(fy);
    dir = d;
    if (is_start) begin start = 1'b1; model_start(); end
    else begin step = 1'b1; model_step(d, fx, fy); end
    lat = 0; got_ate = 0; got_dead = 0; got_len = 0;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        step = 1'b0;
        check("busy_after_accept", int'(busy), 1);
      end
      if (done) begin
        lat = c;
        got_ate = int'(ate);
        got_dead = int'(dead);
        got_len = int'(length);
        break;
      end
    end
    if (lat == 0) check("done_timeout", int'(done), 1);
    @(negedge clk);
    check("done_pulse", int'(done), 0);
    check("busy_released", int'(busy), 0);
    check("plots_drained", exp_q.size(), 0);
  endtask

  task automatic ignore_step(input logic [1:0] d);
    int saw;
    saw = 0;
    @(negedge clk);
    dir = d;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (10) begin
      if (busy || done) saw = 1;
      @(negedge clk);
    end
    check("step_ignored_when_dead", saw, 0);
    check("dead_sticky", int'(dead), 1);
  endtask

  typedef struct {
    bit is_start; logic [1:0] d; int fx; int fy;
    int lat; int ate; int dead; int len;
  } vec_t;

  initial begin
    vec_t tbl[13];
    int lat, g_ate, g_dead, g_len;

    tbl[0]  = '{1'b1, DIR_UP,    0,  0, 52, 0, 0, 3};
    tbl[1]  = '{1'b0, DIR_RIGHT, 0,  0, 39, 0, 0, 3};
    tbl[2]  = '{1'b1, DIR_UP,    0,  0, 52, 0, 0, 3};
    tbl[3]  = '{1'b0, DIR_UP,   20, 14, 23, 1, 0, 4};
    tbl[4]  = '{1'b0, DIR_DOWN,  0,  0, 40, 0, 0, 4};
    tbl[5]  = '{1'b0, DIR_RIGHT,21, 13, 24, 1, 0, 5};
    tbl[6]  = '{1'b0, DIR_DOWN,  0,  0, 41, 0, 0, 5};
    tbl[7]  = '{1'b0, DIR_LEFT,  0,  0,  8, 0, 1, 5};
    tbl[8]  = '{1'b1, DIR_UP,    0,  0, 52, 0, 0, 3};
    tbl[9]  = '{1'b0, DIR_RIGHT,21, 15, 23, 1, 0, 4};
    tbl[10] = '{1'b0, DIR_DOWN,  0,  0, 40, 0, 0, 4};
    tbl[11] = '{1'b0, DIR_LEFT,  0,  0, 40, 0, 0, 4};
    tbl[12] = '{1'b0, DIR_RIGHT, 0,  0, 40, 0, 0, 4};

    repeat (3) @(negedge clk);
    check("rst_length", int'(length), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ate", int'(ate), 0);
    check("rst_dead", int'(dead), 0);
    check("rst_plot_en", int'(plot_en), 0);
    check("rst_plot_x", int'(plot_x), 0);
    check("rst_plot_y", int'(plot_y), 0);
    check("rst_plot_colour", int'(plot_colour), 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      run_op(tbl[i].is_start, tbl[i].d, tbl[i].fx, tbl[i].fy, lat, g_ate, g_dead, g_len);
      check($sformatf("v%0d_latency", i), lat, tbl[i].lat);
      check($sformatf("v%0d_ate", i), g_ate, tbl[i].ate);
      check($sformatf("v%0d_dead", i), g_dead, tbl[i].dead);
      check($sformatf("v%0d_length", i), g_len, tbl[i].len);
      if (i == 7) ignore_step(DIR_UP);
    end

    run_op(1'b1, DIR_UP, 0, 0, lat, g_ate, g_dead, g_len);
    check("edge_start_length", g_len, 3);
    for (int s = 0; s < 20; s++) begin
      run_op(1'b0, DIR_RIGHT, 0, 0, lat, g_ate, g_dead, g_len);
      if (m_lat >= 0) check($sformatf("edge%0d_latency", s), lat, m_lat);
      check($sformatf("edge%0d_dead", s), g_dead, int'(m_dead));
      check($sformatf("edge%0d_length", s), g_len, m_len);
    end
`ifdef SNAKE_WRAP_EN
    check("wrap_alive", int'(dead), 0);
`else
    ignore_step(DIR_UP);
`endif
    run_op(1'b1, DIR_UP, 0, 0, lat, g_ate, g_dead, g_len);
    check("restart_dead", g_dead, 0);
    check("restart_length", g_len, 3);
    check("restart_latency", lat, 52);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
